// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store path: services one request
// after a fixed read/write latency, stalling the core until the access is done.
module dmem_responder #(
    parameter int ADDR_W    = 8,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic                bad_q, bad_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                req_s;
    logic                bad_s;
    logic                stall_s;
    logic                mem_we_s;
    logic [31:0]         mem_q [0:(1 << ADDR_W) - 1];

    // Request decode, error classification, next-state and output logic
    always_comb begin
        req_s    = mem_read | mem_write;
        bad_s    = (addr[1:0] != 2'b00)
                 || ((addr >> (ADDR_W + 2)) != 32'd0)
                 || (mem_read & mem_write);
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        bad_d    = bad_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_s = 1'b0;
        stall_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stall in the request's own cycle so the PC never advances past it
                stall_s = req_s & ~rst;
                if (req_s) begin
                    state_d = S_WAIT;
                    rd_d    = mem_read;
                    bad_d   = bad_s;
                    idx_d   = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    cnt_d   = mem_read ? RD_CNT : WR_CNT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                stall_s = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = bad_q;
                    if (bad_q) begin
                        rdata_d = rdata_q;
                    end else if (rd_q) begin
                        rdata_d = mem_q[idx_q];
                    end else begin
                        mem_we_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign stall = stall_s;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level model checked every cycle plus
// hand-computed latency/data expectations for the directed scenarios.
module tb_dmem_responder;

    localparam int AW = 8;
    localparam int RL = 2;
    localparam int WL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder #(.ADDR_W(AW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted request owns the next LAT+1 cycles
    logic [31:0] mm [int];
    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    bit          m_rd = 1'b0;
    bit          m_bad = 1'b0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_d = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    bit          e_stall, e_done, e_err;

    always @(negedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_rdata = 32'd0;
            e_stall = 1'b0;
            e_done  = 1'b0;
            e_err   = 1'b0;
        end else begin
            if (!m_busy && (mem_read || mem_write)) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_rd   = mem_read;
                m_a    = addr;
                m_d    = wdata;
                m_lat  = mem_read ? RL : WL;
                m_bad  = (addr % 32'd4 != 32'd0) || (addr >= 32'd4 * (32'd1 << AW))
                       || (mem_read && mem_write);
            end
            e_stall = m_busy && (m_k <= m_lat);
            e_done  = m_busy && (m_k == m_lat + 1);
            e_err   = e_done && m_bad;
            if (e_done && !m_bad) begin
                if (m_rd) m_rdata = mm[int'(m_a / 32'd4)];
                else      mm[int'(m_a / 32'd4)] = m_d;
            end
            if (e_done) m_busy = 1'b0;
            else if (m_busy) m_k++;
        end
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("done",  {31'd0, done},  {31'd0, e_done});
        chk("err",   {31'd0, err},   {31'd0, e_err});
        chk("rdata", rdata, m_rdata);
    end

    // Drive one request (starting just after a rising edge) and observe it to completion
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int nst, output logic e,
                          output logic [31:0] r);
        bit got;
        int i;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        nst = 0; e = 1'b0; r = 32'd0; got = 1'b0; i = 0;
        while (!got && i < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                e = err;
                r = rdata;
            end else if (stall) begin
                nst++;
            end
            i++;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done for addr %h within 40 cycles", a);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    int          nst;
    logic        e;
    logic [31:0] r;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, nst, e, r);
        chk("wr_stall_cycles", nst, 32'd2);
        chk("wr_err", {31'd0, e}, 32'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, nst, e, r);
        chk("rd_stall_cycles", nst, 32'd3);
        chk("rd_data", r, 32'hDEADBEEF);
        chk("rd_err", {31'd0, e}, 32'd0);

        do_req(1'b0, 1'b1, 32'h0, 32'h1, nst, e, r);
        do_req(1'b0, 1'b1, 32'h4, 32'h2, nst, e, r);
        chk("b2b_wr_stall", nst, 32'd2);
        do_req(1'b1, 1'b0, 32'h0, 32'd0, nst, e, r);
        chk("b2b_rd0", r, 32'h1);
        do_req(1'b1, 1'b0, 32'h4, 32'd0, nst, e, r);
        chk("b2b_rd4", r, 32'h2);
        chk("b2b_rd_stall", nst, 32'd3);

        do_req(1'b0, 1'b1, 32'hC, 32'h1234, nst, e, r);
        do_req(1'b1, 1'b0, 32'hC, 32'd0, nst, e, r);
        chk("rd_1234", r, 32'h1234);
        do_req(1'b1, 1'b0, 32'h13, 32'd0, nst, e, r);
        chk("misal_err", {31'd0, e}, 32'd1);
        chk("misal_lat", nst, 32'd3);
        chk("misal_rdata", r, 32'h1234);

        do_req(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, nst, e, r);
        chk("oor_err", {31'd0, e}, 32'd1);
        chk("oor_lat", nst, 32'd2);
        do_req(1'b1, 1'b0, 32'h0, 32'd0, nst, e, r);
        chk("oor_alias", r, 32'h1);

        do_req(1'b0, 1'b1, 32'h8, 32'h55, nst, e, r);
        do_req(1'b1, 1'b1, 32'h8, 32'h99, nst, e, r);
        chk("both_err", {31'd0, e}, 32'd1);
        chk("both_lat", nst, 32'd3);
        do_req(1'b1, 1'b0, 32'h8, 32'd0, nst, e, r);
        chk("both_word", r, 32'h55);

        do_req(1'b0, 1'b1, 32'h20, 32'h1111, nst, e, r);
        mem_write = 1'b1;
        addr      = 32'h20;
        wdata     = 32'hAAAA5555;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_done",  {31'd0, done},  32'd0);
        chk("arst_rdata", rdata, 32'd0);
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(1'b1, 1'b0, 32'h20, 32'd0, nst, e, r);
        chk("post_rst_lat", nst, 32'd3);
        chk("post_rst_data", r, 32'h1111);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the processor's load/store interface.
- Accepts one read or write request from the core's control and ALU path (MemRead/MemWrite strobes, ALU result as address, rs data as write data).
- Services each request after a parameterised latency and holds the core with a stall signal until the access completes.
- Sits beside the instruction/time system in the processor top level and replaces a zero-latency data memory.

Parameters:
- ADDR_W, 8, log2 of memory depth in 32-bit words (depth = 2^ADDR_W).
- READ_LAT, 2, WAIT-state cycles for a read; legal range 1..15.
- WRITE_LAT, 1, WAIT-state cycles for a write; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request; held stable by core while stall=1.
- mem_write  in  1  store request; held stable by core while stall=1.
- addr  in  32  byte address (ALU output).
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- stall  out  1  core must hold PC and request while high.
- done  out  1  one-cycle pulse: access complete.
- err  out  1  one-cycle pulse with done: request rejected.

Behaviour:
- Storage: 2^ADDR_W x 32-bit array, word index = addr[ADDR_W+1:2]. Contents are not cleared by rst.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE. Reset values: rdata=0, done=0, err=0, stall=0, counter=0.
- Request definition: req = mem_read | mem_write.
- IDLE:
  - stall = req (combinational), so the core stalls in the same cycle.
  - On req: latch op, addr and wdata; load counter with LAT-1, where LAT = READ_LAT for a read and WRITE_LAT for a write. Go to WAIT.
- WAIT:
  - stall=1.
  - Counter decrements each cycle. When counter=0, perform the access and go to DONE.
  - Write commits to the array on the WAIT->DONE edge.
  - A read loads rdata on the same edge.
- DONE:
  - stall=0; done=1 (registered). err is valid alongside done.
  - The core samples rdata at the end of this cycle.
  - The request present in DONE is the same instruction and is ignored. Next state is always IDLE.
- Timing: a request first seen in IDLE at cycle 0 gives stall high for cycles 0..LAT and done at cycle LAT+1.
- Back-to-back memory instructions: the next request is accepted in IDLE one cycle after DONE.
- rdata holds its value until the next successful read. Writes and errored requests do not change rdata.
- Error conditions, detected from latched values in IDLE:
  - addr[1:0] != 0 (misaligned);
  - addr[31:ADDR_W+2] != 0 (out of range);
  - mem_read & mem_write both high.
- On error:
  - Full latency still elapses (LAT = READ_LAT when mem_read=1, otherwise WRITE_LAT).
  - No array write; rdata unchanged.
  - err=1 together with done.
- Input changes during WAIT are ignored because the latched copy is used.
- rst asserted mid-operation: immediate return to IDLE, stall/done/err low, pending write discarded, array unmodified.
- No new request is accepted in WAIT or DONE.

Test Plan:
- Write then read, READ_LAT=2, WRITE_LAT=1: write 0xDEADBEEF to addr 0x10. Stall is high for 2 cycles and done pulses on cycle 2. Then read 0x10: stall high for 3 cycles, done on cycle 3, rdata=0xDEADBEEF, err=0.
- Back-to-back stores to 0x0 (0x1) and 0x4 (0x2), then loads of both: returns 0x1 and 0x2. Each request is accepted in the IDLE cycle immediately after the previous DONE, and stall is never low during WAIT.
- Misaligned read at 0x13 after rdata=0x1234: full read latency, done=1 and err=1 in the same cycle, rdata stays 0x1234.
- Out-of-range write to 0x400 (ADDR_W=8) with wdata 0xFFFFFFFF: err=1. A subsequent read of 0x0 returns its prior value, proving aliasing did not occur.
- mem_read and mem_write both high at 0x8: err=1 with read latency, word 0x8 unchanged.
- rst pulsed during WAIT of a write of 0xAAAA5555 to 0x20: outputs go to 0 asynchronously. A later read of 0x20 returns the pre-reset value, and the FSM accepts a new request on the first cycle after rst deasserts.
